// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8-bit UART transmitter, 16x oversampled bit timing, optional
//               parity and 1 or 2 stop bits. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       baud_tick_16x,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [2:0] C_STOP_LAST  = (STOP_BITS == 2) ? 3'd1 : 3'd0;
    localparam logic       C_PARITY_ODD = (PARITY_ODD != 0);
    localparam logic       C_PARITY_EN  = (PARITY_EN != 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_tick_cnt;
    logic [3:0] w_tick_nxt;
    logic [2:0] r_bit_cnt;
    logic [2:0] w_bit_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_parity;
    logic       w_parity_nxt;
    logic       r_line;
    logic       r_busy;
    logic       r_done;
    logic       w_line_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_bit_end;

    assign w_bit_end = baud_tick_16x && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_line     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_line     <= w_line_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Parity is fixed at acceptance so the shifting register need not be kept whole.
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;

        if ((r_state == START) || (r_state == DATA) ||
            (r_state == PARITY) || (r_state == STOP)) begin
            if (baud_tick_16x) begin
                w_tick_nxt = r_tick_cnt + 4'd1;
            end
        end

        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (tx_start) begin
                    w_state_nxt  = START;
                    w_shift_nxt  = tx_data;
                    w_parity_nxt = (^tx_data) ^ C_PARITY_ODD;
                    w_tick_nxt   = 4'd0;
                    w_bit_nxt    = 3'd0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_nxt = 3'd0;
                        if (C_PARITY_EN) begin
                            w_state_nxt = PARITY;
                        end else begin
                            w_state_nxt = STOP;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_bit_nxt   = 3'd0;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == C_STOP_LAST) begin
                        w_state_nxt = DONE;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = en ? READY : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the line changes on the same edge as the state.
    always_comb begin
        w_line_nxt = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            START: begin
                w_line_nxt = 1'b0;
                w_busy_nxt = 1'b1;
            end
            DATA: begin
                w_line_nxt = w_shift_nxt[0];
                w_busy_nxt = 1'b1;
            end
            PARITY: begin
                w_line_nxt = w_parity_nxt;
                w_busy_nxt = 1'b1;
            end
            STOP: begin
                w_busy_nxt = 1'b1;
            end
            DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_line_nxt = 1'b1;
            end
        endcase
    end

    assign tx_line = r_line;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire
